// File: rtl/tap_ring_buffer_if.sv
// Loader/datapath-side bundle for tap_ring_buffer: write and read strobes, tap
// offsets and the registered tap results with fill status.
interface tap_ring_buffer_if #(
  parameter int DataWidth   = 8,
  parameter int BufferWidth = 4,
  parameter int NumTaps     = 3
);
  logic                           clk_en;
  logic                           EN;
  logic [DataWidth-1:0]           DataIn;
  logic                           Flush;
  logic                           RdEn;
  logic [NumTaps*BufferWidth-1:0] TapOffset;
  logic [NumTaps*DataWidth-1:0]   DataOut;
  logic [NumTaps-1:0]             TapValid;
  logic                           DataValid;
  logic [BufferWidth:0]           Count;
  logic                           Full;

  modport master (
    output clk_en, EN, DataIn, Flush, RdEn, TapOffset,
    input  DataOut, TapValid, DataValid, Count, Full
  );

  modport slave (
    input  clk_en, EN, DataIn, Flush, RdEn, TapOffset,
    output DataOut, TapValid, DataValid, Count, Full
  );
endinterface

// File: rtl/tap_ring_buffer.sv
// Circular sample buffer with an auto-incrementing write pointer and NumTaps
// read taps addressed backwards from the newest sample (offset 0 = newest).
module tap_ring_buffer #(
  parameter int DataWidth   = 8,
  parameter int BufferSize  = 16,
  parameter int BufferWidth = 4,
  parameter int NumTaps     = 3
) (
  input logic             clk,
  input logic             aclr,
  tap_ring_buffer_if.slave bus
);

  localparam logic [BufferWidth:0] CountMax = (BufferWidth+1)'(BufferSize);

  logic [DataWidth-1:0]         mem [BufferSize];
  logic [BufferWidth-1:0]       wr_ptr;
  logic [BufferWidth:0]         count;
  logic [NumTaps*DataWidth-1:0] data_out;
  logic [NumTaps-1:0]           tap_valid;
  logic                         data_valid;

  logic [BufferWidth-1:0]       rd_addr [NumTaps];
  logic [NumTaps-1:0]           tap_hit;

  // Tap address is newest slot minus offset; modular wrap comes from the pointer width.
  function automatic logic [BufferWidth-1:0] tap_addr(
    input logic [BufferWidth-1:0] ptr,
    input logic [BufferWidth-1:0] offset
  );
    return ptr - BufferWidth'(1) - offset;
  endfunction

  // Per-tap read address and validity, computed from the pre-edge pointer and fill level.
  always_comb begin
    rd_addr = '{default: '0};
    tap_hit = '0;
    for (int k = 0; k < NumTaps; k++) begin
      rd_addr[k] = tap_addr(wr_ptr, bus.TapOffset[k*BufferWidth +: BufferWidth]);
      tap_hit[k] = ({1'b0, bus.TapOffset[k*BufferWidth +: BufferWidth]} < count);
    end
  end

  // Ring state and registered tap outputs; aclr clears everything, Flush only the bookkeeping.
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int i = 0; i < BufferSize; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      tap_valid  <= '0;
      data_valid <= 1'b0;
    end else if (bus.clk_en) begin
      if (bus.Flush) begin
        wr_ptr     <= '0;
        count      <= '0;
        tap_valid  <= '0;
        data_valid <= 1'b0;
      end else begin
        if (bus.EN) begin
          mem[wr_ptr] <= bus.DataIn;
          wr_ptr      <= wr_ptr + BufferWidth'(1);
          if (count != CountMax) begin
            count <= count + (BufferWidth+1)'(1);
          end
        end
        // Reads see pre-edge memory, so a same-edge write shows up on the next read.
        if (bus.RdEn) begin
          for (int k = 0; k < NumTaps; k++) begin
            data_out[k*DataWidth +: DataWidth] <= mem[rd_addr[k]];
          end
          tap_valid  <= tap_hit;
          data_valid <= 1'b1;
        end else begin
          data_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.DataOut   = data_out;
  assign bus.TapValid  = tap_valid;
  assign bus.DataValid = data_valid;
  assign bus.Count     = count;
  assign bus.Full      = (count == CountMax);

endmodule

// File: tb/tb_tap_ring_buffer.sv
// Directed self-checking bench for tap_ring_buffer with hand-computed expectations.
module tb_tap_ring_buffer;

  logic clk;
  logic aclr;
  int   n_checks;
  int   n_fail;

  tap_ring_buffer_if #(.DataWidth(8), .BufferWidth(4), .NumTaps(3)) bus ();

  tap_ring_buffer #(
    .DataWidth(8), .BufferSize(16), .BufferWidth(4), .NumTaps(3)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.EN = 1'b1; bus.DataIn = d;
    tick();
    bus.EN = 1'b0;
  endtask

  task automatic rd(input logic [3:0] o2, input logic [3:0] o1, input logic [3:0] o0);
    bus.RdEn = 1'b1; bus.TapOffset = {o2, o1, o0};
    tick();
    bus.RdEn = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    aclr = 1'b1;
    bus.clk_en = 1'b1; bus.EN = 1'b0; bus.DataIn = 8'h00;
    bus.Flush = 1'b0; bus.RdEn = 1'b0; bus.TapOffset = 12'h000;
    tick(); tick();
    aclr = 1'b0;

    // Traffic, then reset with a read pulse outstanding
    wr(8'hA1); wr(8'hA2);
    bus.RdEn = 1'b1; bus.TapOffset = 12'h010;
    tick();
    check_val("pre_reset_valid", 32'(bus.DataValid), 32'h1);
    aclr = 1'b1;
    tick();
    aclr = 1'b0; bus.RdEn = 1'b0;
    check_val("rst_count", 32'(bus.Count), 32'h0);
    check_val("rst_full", 32'(bus.Full), 32'h0);
    check_val("rst_dout", 32'(bus.DataOut), 32'h0);
    check_val("rst_tvalid", 32'(bus.TapValid), 32'h0);
    check_val("rst_dvalid", 32'(bus.DataValid), 32'h0);

    // Empty read: memory cleared, nothing valid, pulse still issued
    rd(4'd2, 4'd1, 4'd0);
    check_val("empty_dout", 32'(bus.DataOut), 32'h0);
    check_val("empty_tvalid", 32'(bus.TapValid), 32'h0);
    check_val("empty_dvalid", 32'(bus.DataValid), 32'h1);

    // Basic taps
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    rd(4'd4, 4'd1, 4'd0);
    check_val("basic_dout", 32'(bus.DataOut), 32'h101314);
    check_val("basic_tvalid", 32'(bus.TapValid), 32'h7);
    check_val("basic_dvalid", 32'(bus.DataValid), 32'h1);
    check_val("basic_count", 32'(bus.Count), 32'h5);
    tick();
    check_val("basic_pulse_end", 32'(bus.DataValid), 32'h0);
    check_val("basic_hold", 32'(bus.DataOut), 32'h101314);

    // Offsets beyond the fill level: raw (cleared) word, tap marked invalid
    rd(4'd7, 4'd5, 4'd0);
    check_val("inval_dout", 32'(bus.DataOut), 32'h000014);
    check_val("inval_tvalid", 32'(bus.TapValid), 32'h1);

    // Read-old collision, then the new sample appears at offset 0
    bus.EN = 1'b1; bus.DataIn = 8'hAA;
    rd(4'd0, 4'd0, 4'd0);
    bus.EN = 1'b0;
    check_val("coll_dout", 32'(bus.DataOut), 32'h141414);
    check_val("coll_count", 32'(bus.Count), 32'h6);
    rd(4'd1, 4'd1, 4'd0);
    check_val("coll_next", 32'(bus.DataOut), 32'h1414AA);

    // Wrap and saturation
    aclr = 1'b1; tick(); aclr = 1'b0;
    for (int i = 0; i < 20; i++) wr(8'(i));
    check_val("wrap_count", 32'(bus.Count), 32'h10);
    check_val("wrap_full", 32'(bus.Full), 32'h1);
    rd(4'd3, 4'd15, 4'd0);
    check_val("wrap_dout", 32'(bus.DataOut), 32'h100413);
    check_val("wrap_tvalid", 32'(bus.TapValid), 32'h7);

    // clk_en low freezes everything, including the DataValid pulse
    bus.clk_en = 1'b0; bus.EN = 1'b1; bus.DataIn = 8'h99;
    bus.RdEn = 1'b1; bus.Flush = 1'b1; bus.TapOffset = 12'h000;
    tick(); tick(); tick();
    check_val("cen_count", 32'(bus.Count), 32'h10);
    check_val("cen_dout", 32'(bus.DataOut), 32'h100413);
    check_val("cen_dvalid", 32'(bus.DataValid), 32'h1);
    bus.clk_en = 1'b1; bus.EN = 1'b0; bus.Flush = 1'b0;
    rd(4'd0, 4'd0, 4'd0);
    check_val("cen_resume", 32'(bus.DataOut), 32'h131313);

    // Flush drops the simultaneous write and read, keeps memory and DataOut
    bus.Flush = 1'b1; bus.EN = 1'b1; bus.DataIn = 8'h77; bus.RdEn = 1'b1;
    tick();
    bus.Flush = 1'b0; bus.EN = 1'b0; bus.RdEn = 1'b0;
    check_val("flush_count", 32'(bus.Count), 32'h0);
    check_val("flush_full", 32'(bus.Full), 32'h0);
    check_val("flush_dvalid", 32'(bus.DataValid), 32'h0);
    check_val("flush_tvalid", 32'(bus.TapValid), 32'h0);
    check_val("flush_dout", 32'(bus.DataOut), 32'h131313);
    wr(8'h55);
    rd(4'd1, 4'd1, 4'd0);
    check_val("flush_rd_dout", 32'(bus.DataOut), 32'h0F0F55);
    check_val("flush_rd_tvalid", 32'(bus.TapValid), 32'h1);
    check_val("flush_rd_count", 32'(bus.Count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
